// File: rtl/ram_n16.sv
// Register-file RAM of WORDS 16-bit words with a combinational read port and a
// one-word-per-cycle background clear sweep that locks out user writes while busy.
module ram_n16 #(
    parameter int WORDS = 8,
    localparam int ADDR_WIDTH = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           in,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  clear,
    output logic                  busy,
    output logic [15:0]           out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORDS - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [15:0]             mem [WORDS];
    logic [WORDS-1:0]        write_sel;

    // A clear request in IDLE takes precedence, so the same-cycle write is dropped.
    always_comb begin
        write_sel = '0;
        if (state == IDLE && load && !clear) begin
            write_sel[address] = 1'b1;
        end
    end

    always_comb begin
        out = mem[address];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (write_sel[i]) begin
                    mem[i] <= in;
                end
            end
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // ptr wraps to 0 on the same edge that ends the sweep.
                    mem[ptr] <= '0;
                    ptr      <= ptr + ADDR_WIDTH'(1);
                    if (ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_n16.sv
// Bench for ram_n16: runs every scenario on a WORDS=4 and a WORDS=8 instance,
// selecting which one receives the control strobes and is observed.
module tb_ram_n16;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  address = '0;
    int          sel = 0;
    int          words = 4;

    logic        busy4, busy8;
    logic [15:0] out4, out8;
    logic        cur_busy;
    logic [15:0] cur_out;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ram_n16 #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in(in),
        .load(load && sel == 0), .address(address[1:0]),
        .clear(clear && sel == 0), .busy(busy4), .out(out4)
    );

    ram_n16 #(.WORDS(8)) dut8 (
        .clk(clk), .rst(rst), .in(in),
        .load(load && sel == 1), .address(address[2:0]),
        .clear(clear && sel == 1), .busy(busy8), .out(out8)
    );

    assign cur_busy = (sel == 1) ? busy8 : busy4;
    assign cur_out  = (sel == 1) ? out8 : out4;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clk);
        address = 6'(a);
        in = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < words; i++) begin
            write_word(i, 16'h1111 + 16'(i));
        end
    endtask

    // Counts negedges with busy high; returns -1 if the sweep never ends.
    task automatic wait_busy_low(output int cnt);
        cnt = 0;
        while (cur_busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 200) cnt = -1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        checks++;
        if (cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy W=%0d got %b want 0", words, cur_busy);
        end
        for (int i = 0; i < words; i++) begin
            sb.push_back('{"reset_zero", 16'h0000});
            address = 6'(i);
            #1;
            e = sb.pop_front();
            checks++;
            if (cur_out !== e.val) begin
                errors++;
                $display("[TB] FAIL %s W=%0d addr %0d got %h want %h", e.tag, words, i, cur_out, e.val);
            end
        end
    endtask

    task automatic test_readback();
        exp_t e;
        do_reset();
        fill_all();
        @(negedge clk);
        for (int i = 0; i < words; i++) begin
            sb.push_back('{"readback", 16'h1111 + 16'(i)});
            address = 6'(i);
            #1;
            e = sb.pop_front();
            checks++;
            if (cur_out !== e.val) begin
                errors++;
                $display("[TB] FAIL %s W=%0d addr %0d got %h want %h", e.tag, words, i, cur_out, e.val);
            end
        end
    endtask

    task automatic test_read_during_write();
        exp_t e;
        write_word(2, 16'hAAAA);
        @(negedge clk);
        address = 6'd2;
        in = 16'h5555;
        load = 1'b1;
        sb.push_back('{"rdw_old", 16'hAAAA});
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
        @(negedge clk);
        load = 1'b0;
        sb.push_back('{"rdw_new", 16'h5555});
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
        sb.push_back('{"rdw_neighbor", 16'h1112});
        address = 6'd1;
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
    endtask

    // hold_cycles > 1 also exercises that clear is ignored once the sweep runs.
    task automatic test_clear_sweep(input int hold_cycles);
        exp_t e;
        int   cnt;
        fill_all();
        @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k < hold_cycles; k++) @(negedge clk);
        clear = 1'b0;
        cnt = hold_cycles - 1;
        begin
            int rest;
            wait_busy_low(rest);
            cnt = (rest < 0) ? -1 : cnt + rest;
        end
        checks++;
        if (cnt != words) begin
            errors++;
            $display("[TB] FAIL sweep_len W=%0d hold=%0d got %0d want %0d", words, hold_cycles, cnt, words);
        end
        for (int i = 0; i < words; i++) begin
            sb.push_back('{"swept_zero", 16'h0000});
            address = 6'(i);
            #1;
            e = sb.pop_front();
            checks++;
            if (cur_out !== e.val) begin
                errors++;
                $display("[TB] FAIL %s W=%0d addr %0d got %h want %h", e.tag, words, i, cur_out, e.val);
            end
        end
    endtask

    task automatic test_write_blocked();
        exp_t e;
        int   cnt;
        fill_all();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b1;
        address = 6'(words - 1);
        in = 16'hBEEF;
        wait_busy_low(cnt);
        load = 1'b0;
        checks++;
        if (cnt != words) begin
            errors++;
            $display("[TB] FAIL blocked_len W=%0d got %0d want %0d", words, cnt, words);
        end
        sb.push_back('{"blocked_write", 16'h0000});
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
    endtask

    task automatic test_priority_and_reset();
        exp_t e;
        fill_all();
        @(negedge clk);
        clear = 1'b1;
        load = 1'b1;
        address = 6'(words - 1);
        in = 16'hCAFE;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b0;
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_busy W=%0d got %b want 1", words, cur_busy);
        end
        sb.push_back('{"prio_dropped", 16'h1111 + 16'(words - 1)});
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
        @(negedge clk);
        sb.push_back('{"partial_zero", 16'h0000});
        address = 6'd0;
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
        sb.push_back('{"partial_live", 16'h1112});
        address = 6'd1;
        #1;
        e = sb.pop_front();
        checks++;
        if (cur_out !== e.val) begin
            errors++;
            $display("[TB] FAIL %s W=%0d got %h want %h", e.tag, words, cur_out, e.val);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midsweep_rst_busy W=%0d got %b want 0", words, cur_busy);
        end
        for (int i = 0; i < words; i++) begin
            sb.push_back('{"midsweep_rst_zero", 16'h0000});
            address = 6'(i);
            #1;
            e = sb.pop_front();
            checks++;
            if (cur_out !== e.val) begin
                errors++;
                $display("[TB] FAIL %s W=%0d addr %0d got %h want %h", e.tag, words, i, cur_out, e.val);
            end
        end
        @(negedge clk);
        checks++;
        if (cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sweep_abandoned W=%0d got %b want 0", words, cur_busy);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s;
            words = (s == 1) ? 8 : 4;
            $display("[TB] running scenarios for WORDS=%0d", words);
            test_reset();
            test_readback();
            test_read_during_write();
            test_clear_sweep(1);
            test_clear_sweep(3);
            test_write_blocked();
            test_priority_and_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
